floor_request_scheduler: RTL and testbench
==========================================

# floor_request_scheduler

Latches per-floor call pulses coming out of the push-button debouncers and selects the next target floor for the elevator motion controller. It uses a SCAN policy: keep moving in the current direction while requests remain ahead, then reverse. It sits between the bank of debouncers, which feed it single-cycle pulses, and the car/door controller, which consumes `target`/`dir` and reports arrivals back.

## Interface
- `FLOORS`, default 4: number of floors. Legal range 2..16.
- `FLOOR_W`, default 2: floor index width. Must satisfy 2^FLOOR_W >= FLOORS.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_pulse`  in  FLOORS  one-cycle request pulses, bit i = floor i, driven by the debouncers.
- `cur_floor`  in  FLOOR_W  floor the car is currently at or passing.
- `arrived`  in  1  one-cycle pulse: the car has stopped at `cur_floor` and the doors are opening.
- `pending`  out  FLOORS  registered request set.
- `target`  out  FLOOR_W  registered next floor to serve.
- `target_valid`  out  1  high when `target` is meaningful.
- `dir`  out  2  registered direction: 00 idle, 01 up, 10 down. 11 is never driven.

## Operation
- **Request latch**, per bit i, each cycle:
  - set if `req_pulse[i]`;
  - clear if `arrived` and `cur_floor == i`;
  - if set and clear occur together, clear wins (the car is already serving that floor);
  - otherwise hold.
- A repeated pulse, or a held-high input, on an already pending floor has no extra effect.
- `arrived` with `cur_floor >= FLOORS` clears nothing.
- **Scheduler FSM**: states IDLE, UP, DOWN. Next state and target are computed from the registered `pending`, the current state and `cur_floor`. "Above" and "below" are strict comparisons against `cur_floor`.
- **IDLE**:
  - no bits pending: stay IDLE, `target_valid`=0, `target` holds its last value;
  - `pending[cur_floor]` set: stay IDLE, `target`=`cur_floor`, `target_valid`=1;
  - else any pending above: go to UP;
  - else (pending below): go to DOWN.
- **UP**:
  - target is the lowest pending floor >= `cur_floor`;
  - if none exists and any are pending below: go to DOWN, target is the highest pending floor below;
  - if nothing is pending: go to IDLE.
- **DOWN**: mirror of UP.
  - target is the highest pending floor <= `cur_floor`;
  - if none exists and any are pending above: go to UP, target is the lowest pending floor above;
  - if nothing is pending: go to IDLE.
- **Target selection**: within a direction, a new request closer to the car in the travel direction preempts the current target. The direction never reverses while a request remains ahead.
- **Output encoding**: `dir` encodes the registered state. `target_valid` = 1 whenever `pending` != 0 in the cycle the outputs are computed.
- Widths: all comparisons are unsigned on FLOOR_W bits. No arithmetic wrap is possible.

## Timing
- Reset (`rst`=0), effective asynchronously and at any time including mid-travel:
  - `pending`=0, state IDLE, `dir`=00, `target`=0, `target_valid`=0;
  - outputs hold these values until the first rising `clk` after `rst` returns high.
- Latency:
  - `req_pulse[i]` at edge N → `pending[i]`=1 after edge N+1;
  - `dir`/`target`/`target_valid` reflect it after edge N+2.
- `arrived` at edge N → pending bit clears after N+1; scheduler outputs update after N+2.
- There is no handshake. The downstream controller samples `target`/`dir` every cycle and must tolerate a target change on any cycle.
- Simultaneous pulses on several floors in one cycle are all latched.

## Test plan
- **Async reset mid-operation**: with `pending`=1010 and `dir`=01, drive `rst`=0 between clock edges → all outputs 0 immediately, with no clock edge required.
- **Single request**: `cur_floor`=0, `req_pulse`=0100 for one cycle →
  - `pending`=0100 one cycle later;
  - `dir`=01, `target`=2, `target_valid`=1 the following cycle;
  - `cur_floor`=2 with an `arrived` pulse → `pending`=0000, then `dir`=00 and `target_valid`=0.
- **Preempt and reverse**: UP with `cur_floor`=1 and `target`=3; pulse floors 0 and 2 →
  - `target`=2, `dir` stays 01;
  - arrive at 2 → `target`=3;
  - arrive at 3 → `dir`=10, `target`=0.
- **Same-cycle set and clear**: `cur_floor`=1, `req_pulse`=0010 together with `arrived` → `pending[1]` remains 0.
- **Request at current floor while IDLE**: `cur_floor`=3, pulse floor 3 → `dir`=00, `target`=3, `target_valid`=1.
- **Redundant input**: hold `req_pulse[2]`=1 for 5 cycles, and pulse `arrived` with `cur_floor`=5 when FLOORS=4 → `pending` is simply 0100 with no glitches, and the out-of-range arrival clears nothing.

Source files
------------

// File: rtl/floor_request_scheduler.sv
// Latches per-floor call pulses and picks the next target floor with a SCAN
// (elevator) policy: keep going while requests remain ahead, then reverse.
module floor_request_scheduler #(
    parameter int FLOORS  = 4,
    parameter int FLOOR_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOORS-1:0]  req_pulse,
    input  logic [FLOOR_W-1:0] cur_floor,
    input  logic               arrived,
    output logic [FLOORS-1:0]  pending,
    output logic [FLOOR_W-1:0] target,
    output logic               target_valid,
    output logic [1:0]         dir
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [FLOOR_W-1:0] target_nxt;
    logic               valid_nxt;
    logic [FLOORS-1:0]  clear_mask;
    logic [FLOOR_W-1:0] lo_ge;
    logic [FLOOR_W-1:0] hi_le;
    logic               found_ge;
    logic               found_le;
    logic               at_cur;

    // An out-of-range cur_floor matches no index, so it clears nothing.
    always_comb begin
        clear_mask = '0;
        for (int i = 0; i < FLOORS; i++) begin
            clear_mask[i] = arrived && (cur_floor == FLOOR_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= (pending | req_pulse) & ~clear_mask;
        end
    end

    // Nearest pending floor at-or-above and at-or-below the car.
    always_comb begin
        lo_ge    = '0;
        found_ge = 1'b0;
        hi_le    = '0;
        found_le = 1'b0;
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) >= cur_floor)) begin
                lo_ge    = FLOOR_W'(i);
                found_ge = 1'b1;
            end
        end
        for (int i = 0; i < FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) <= cur_floor)) begin
                hi_le    = FLOOR_W'(i);
                found_le = 1'b1;
            end
        end
        at_cur = found_ge && (lo_ge == cur_floor);
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        valid_nxt  = |pending;
        case (state)
            IDLE: begin
                if (|pending) begin
                    if (at_cur) begin
                        target_nxt = cur_floor;
                    end else if (found_ge) begin
                        state_nxt  = UP;
                        target_nxt = lo_ge;
                    end else begin
                        state_nxt  = DOWN;
                        target_nxt = hi_le;
                    end
                end
            end
            UP: begin
                if (found_ge) begin
                    target_nxt = lo_ge;
                end else if (found_le) begin
                    state_nxt  = DOWN;
                    target_nxt = hi_le;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DOWN: begin
                if (found_le) begin
                    target_nxt = hi_le;
                end else if (found_ge) begin
                    state_nxt  = UP;
                    target_nxt = lo_ge;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            target       <= '0;
            target_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            target       <= target_nxt;
            target_valid <= valid_nxt;
        end
    end

    assign dir = state;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Bench for floor_request_scheduler: directed scenarios with literal expectations,
// then random traffic compared every cycle against a list-based SCAN model.
module tb_floor_request_scheduler;

    localparam int FLOORS  = 4;
    localparam int FLOOR_W = 3;

    logic               clk;
    logic               rst;
    logic [FLOORS-1:0]  req_pulse;
    logic [FLOOR_W-1:0] cur_floor;
    logic               arrived;
    logic [FLOORS-1:0]  pending;
    logic [FLOOR_W-1:0] target;
    logic               target_valid;
    logic [1:0]         dir;

    int total = 0;
    int bad   = 0;
    bit check_en = 0;

    logic [FLOORS-1:0] m_pend;
    int                m_dir;
    int                m_tgt;
    int                m_valid;

    floor_request_scheduler #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) dut (
        .clk(clk),
        .rst(rst),
        .req_pulse(req_pulse),
        .cur_floor(cur_floor),
        .arrived(arrived),
        .pending(pending),
        .target(target),
        .target_valid(target_valid),
        .dir(dir)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [FLOORS-1:0] req, input int cur, input logic arr);
        @(negedge clk);
        req_pulse = req;
        cur_floor = FLOOR_W'(cur);
        arrived   = arr;
        @(negedge clk);
        req_pulse = '0;
        arrived   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // SCAN model: work from the list of pending floor numbers each cycle.
    always @(posedge clk or negedge rst) begin
        int floors[$];
        int cur, best;
        bit found;
        if (!rst) begin
            m_pend  = '0;
            m_dir   = 0;
            m_tgt   = 0;
            m_valid = 0;
        end else begin
            floors.delete();
            for (int i = 0; i < FLOORS; i++) if (m_pend[i]) floors.push_back(i);
            cur = int'(cur_floor);
            if (floors.size() == 0) begin
                m_dir   = 0;
                m_valid = 0;
            end else begin
                m_valid = 1;
                if (m_dir == 0 && m_pend[cur % FLOORS] && cur < FLOORS) begin
                    m_tgt = cur;
                end else begin
                    // Prefer continuing in the current direction (idle counts as up-first).
                    for (int pass = 0; pass < 2; pass++) begin
                        int want;
                        want = (pass == 0) ? ((m_dir == 2) ? 2 : 1) : ((m_dir == 2) ? 1 : 2);
                        found = 0;
                        best = 0;
                        foreach (floors[k]) begin
                            if (want == 1 && floors[k] >= cur && (!found || floors[k] < best)) begin
                                best = floors[k]; found = 1;
                            end
                            if (want == 2 && floors[k] <= cur && (!found || floors[k] > best)) begin
                                best = floors[k]; found = 1;
                            end
                        end
                        if (found) begin
                            m_dir = want;
                            m_tgt = best;
                            break;
                        end
                    end
                end
            end
            for (int i = 0; i < FLOORS; i++) begin
                if (arrived && cur == i) m_pend[i] = 1'b0;
                else if (req_pulse[i])   m_pend[i] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_pending", pending, m_pend);
            checkOutput("model_dir", dir, m_dir);
            checkOutput("model_valid", target_valid, m_valid);
            if (m_valid != 0) checkOutput("model_target", target, m_tgt);
        end
    end

    initial begin
        rst = 1; req_pulse = '0; cur_floor = '0; arrived = 0;
        #2 rst = 0;
        #1;
        check_en = 1;
        checkOutput("reset_pending", pending, 0);
        checkOutput("reset_dir", dir, 0);
        checkOutput("reset_target", target, 0);
        checkOutput("reset_valid", target_valid, 0);
        idle(2);
        rst = 1;

        // single request
        applyStimulus(4'b0100, 0, 0);
        checkOutput("single_pending", pending, 4'b0100);
        idle(1);
        checkOutput("single_dir", dir, 2'b01);
        checkOutput("single_target", target, 2);
        checkOutput("single_valid", target_valid, 1);
        applyStimulus(4'b0000, 2, 1);
        checkOutput("single_clear", pending, 0);
        idle(1);
        checkOutput("single_idle_dir", dir, 0);
        checkOutput("single_idle_valid", target_valid, 0);

        // preempt and reverse
        applyStimulus(4'b1000, 1, 0);
        idle(1);
        checkOutput("pre_target3", target, 3);
        applyStimulus(4'b0101, 1, 0);
        idle(1);
        checkOutput("pre_target2", target, 2);
        checkOutput("pre_dir_up", dir, 2'b01);
        applyStimulus(4'b0000, 2, 1);
        idle(1);
        checkOutput("pre_after2", target, 3);
        applyStimulus(4'b0000, 3, 1);
        idle(1);
        checkOutput("rev_dir", dir, 2'b10);
        checkOutput("rev_target", target, 0);
        applyStimulus(4'b0000, 0, 1);
        idle(2);

        // set and clear in the same cycle
        applyStimulus(4'b0010, 1, 1);
        checkOutput("set_clear", pending, 0);
        idle(1);

        // request at current floor while idle
        applyStimulus(4'b1000, 3, 0);
        idle(1);
        checkOutput("here_dir", dir, 0);
        checkOutput("here_target", target, 3);
        checkOutput("here_valid", target_valid, 1);
        applyStimulus(4'b0000, 3, 1);
        idle(1);

        // held request and out-of-range arrival
        @(negedge clk);
        req_pulse = 4'b0100;
        cur_floor = 0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("hold_pending", pending, 4'b0100);
        end
        req_pulse = '0;
        applyStimulus(4'b0000, 5, 1);
        checkOutput("oob_arrive", pending, 4'b0100);
        applyStimulus(4'b0000, 2, 1);
        idle(2);

        // asynchronous reset mid-travel
        applyStimulus(4'b1010, 0, 0);
        idle(1);
        checkOutput("pre_reset_dir", dir, 2'b01);
        @(posedge clk);
        #3 rst = 0;
        #1;
        checkOutput("async_pending", pending, 0);
        checkOutput("async_dir", dir, 0);
        checkOutput("async_target", target, 0);
        checkOutput("async_valid", target_valid, 0);
        @(negedge clk);
        rst = 1;

        repeat (3000) begin
            @(negedge clk);
            req_pulse = ($urandom_range(0, 3) == 0) ? FLOORS'($urandom) : '0;
            cur_floor = FLOOR_W'($urandom_range(0, 5));
            arrived   = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        req_pulse = '0;
        arrived = 0;
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
